coin_dispenser: RTL and testbench
=================================

COIN_DISPENSER -- requirements
Module: coin_dispenser

Interface
REQ-001 SHALL have parameter EJECT_GAP, default 4, minimum idle cycles between consecutive ejects.
REQ-002 SHALL have parameter ACK_TIMEOUT, default 255, maximum cycles o_eject may wait for i_eject_ack (used only with the timeout feature).
REQ-003 SHALL have port i_clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port i_rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port i_soda  input  1  one-cycle vend strobe from the vending controller.
REQ-006 SHALL have port i_change  input  3  change owed in nickels; valid only while i_soda=1.
REQ-007 SHALL have port o_eject  output  1  request to hopper to eject one nickel.
REQ-008 SHALL have port i_eject_ack  input  1  hopper confirms one nickel ejected.
REQ-009 SHALL have port o_coins_left  output  3  nickels still owed for the current vend.
REQ-010 SHALL have port o_busy  output  1  high when not IDLE or the queue is non-empty.
REQ-011 SHALL have port o_done  output  1  one-cycle pulse when a vend's change is fully paid.
REQ-012 SHALL have port o_overflow  output  1  sticky; a vend was dropped because the queue was full.
REQ-013 SHALL have port o_fault  output  1  sticky ack-timeout flag; tied 0 without DISPENSE_TIMEOUT_EN.

Function
REQ-014 SHALL push i_change into a 2-entry FIFO on every cycle with i_soda=1, including i_change=0.
REQ-015 SHALL drop the push and set o_overflow when i_soda=1 and the FIFO is full, unless a pop occurs in the same cycle, in which case the push succeeds.
REQ-016 SHALL implement FSM states IDLE, LOAD, EJECT, GAP, DONE (FAULT with the timeout feature).
REQ-017 IDLE -> LOAD when the FIFO is non-empty; LOAD pops the head into o_coins_left.
REQ-018 LOAD -> DONE if the popped value is 0, else -> EJECT.
REQ-019 EJECT SHALL hold o_eject=1 until i_eject_ack=1 is sampled, then decrement o_coins_left by 1 in that cycle.
REQ-020 After an ack in EJECT: -> DONE if o_coins_left becomes 0, else -> GAP.
REQ-021 GAP SHALL keep o_eject=0 for exactly EJECT_GAP cycles, then -> EJECT.
REQ-022 DONE SHALL assert o_done for one cycle, then -> IDLE; back-to-back queued vends therefore have at least one IDLE cycle between them.
REQ-023 SHALL ignore i_eject_ack outside EJECT; it SHALL NOT change o_coins_left.
REQ-024 Latency: i_soda with i_change=1 into an empty idle block SHALL raise o_eject 3 cycles later (push, LOAD, EJECT).
REQ-025 o_coins_left SHALL never wrap below 0.

Reset
REQ-026 When i_rst_n=0 at a clock edge: FSM -> IDLE, FIFO empty, o_eject=0, o_coins_left=0, o_busy=0, o_done=0, o_overflow=0, o_fault=0.
REQ-027 Reset mid-dispense SHALL abandon the owed change without further ejects.

Configuration
REQ-028 With macro DISPENSE_TIMEOUT_EN defined: a cycle counter runs in EJECT; if ACK_TIMEOUT cycles pass without ack, -> FAULT; o_eject=0 and o_fault=1 sticky. FAULT exits only by reset. New vends are still queued and may overflow.
REQ-029 Without DISPENSE_TIMEOUT_EN: no counter or FAULT state; EJECT waits indefinitely; o_fault is constant 0.

Structure
REQ-030 Shared package vend_pkg SHALL hold the FSM state enum, the coin-count width (3), and the nickel unit constant.
REQ-031 The FIFO SHALL be sub-module change_fifo (2 x 3-bit, push/pop/full/empty).

Verification
REQ-032 i_soda with i_change=3, ack 1 cycle after each o_eject -> three ejects separated by 4-cycle gaps, o_coins_left 3->2->1->0, one o_done.
REQ-033 i_soda with i_change=0 -> no o_eject, o_done 3 cycles after the strobe.
REQ-034 Three strobes (2,1,4) with ack held low -> first two queued, third sets o_overflow=1; releasing ack pays 2 then 1.
REQ-035 Reset asserted with o_coins_left=2 -> all outputs 0 on the next cycle, no further ejects.
REQ-036 With DISPENSE_TIMEOUT_EN and ACK_TIMEOUT=10, no ack -> o_fault=1 after 10 EJECT cycles, o_eject=0 and held until reset.

Source files
------------

// File: rtl/vend_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vend_pkg
// Description : Shared definitions for the coin dispenser: coin-count width,
//               the nickel unit, and the dispenser FSM state encoding.
//               With DISPENSE_TIMEOUT_EN defined the FAULT state is added.
// Revision    : 1.0 - initial release
// ============================================================================
package vend_pkg;

    localparam int c_coin_w = 3;
    localparam logic [c_coin_w-1:0] c_nickel = 3'd1;

`ifdef DISPENSE_TIMEOUT_EN
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_EJECT = 3'd2,
        S_GAP   = 3'd3,
        S_DONE  = 3'd4,
        S_FAULT = 3'd5
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_EJECT = 3'd2,
        S_GAP   = 3'd3,
        S_DONE  = 3'd4
    } state_t;
`endif

endpackage
`default_nettype wire

// File: rtl/change_fifo.sv
`default_nettype none
// ============================================================================
// Module      : change_fifo
// Description : Two-entry FIFO of 3-bit change amounts.
//               Ports: i_clk, i_rst_n (sync, active-low), i_push, i_pop,
//               i_data -> o_data (head), o_full, o_empty.
//               A push while full is accepted only when a pop happens in the
//               same cycle; a pop while empty is ignored.
// Revision    : 1.0 - initial release
// ============================================================================
module change_fifo
    import vend_pkg::*;
(
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_push,
    input  logic                i_pop,
    input  logic [c_coin_w-1:0] i_data,
    output logic [c_coin_w-1:0] o_data,
    output logic                o_full,
    output logic                o_empty
);

    logic [c_coin_w-1:0] r_mem [2];
    logic                r_wr_ptr;
    logic                r_rd_ptr;
    logic [1:0]          r_count;
    logic                w_do_push;
    logic                w_do_pop;

    assign o_full    = (r_count == 2'd2);
    assign o_empty   = (r_count == 2'd0);
    assign o_data    = r_mem[r_rd_ptr];
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_do_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= r_count + 2'(w_do_push) - 2'(w_do_pop);
        end
    end

endmodule
`default_nettype wire

// File: rtl/coin_dispenser.sv
`default_nettype none
// ============================================================================
// Module      : coin_dispenser
// Description : Pays out vend change one nickel at a time through a hopper.
//               Vend strobes queue their change in a 2-entry FIFO; an FSM
//               loads each amount, handshakes one eject per nickel and keeps
//               EJECT_GAP idle cycles between ejects.
//               Ports: i_clk, i_rst_n (sync, active-low), i_soda, i_change,
//               i_eject_ack -> o_eject, o_coins_left, o_busy, o_done,
//               o_overflow (sticky), o_fault (sticky).
//               Macro DISPENSE_TIMEOUT_EN: adds an ack timeout that parks the
//               FSM in FAULT (exit only by reset); otherwise o_fault is 0.
// Revision    : 1.0 - initial release
// ============================================================================
module coin_dispenser
    import vend_pkg::*;
#(
    parameter int EJECT_GAP   = 4,
    parameter int ACK_TIMEOUT = 255
)(
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_soda,
    input  logic [c_coin_w-1:0] i_change,
    output logic                o_eject,
    input  logic                i_eject_ack,
    output logic [c_coin_w-1:0] o_coins_left,
    output logic                o_busy,
    output logic                o_done,
    output logic                o_overflow,
    output logic                o_fault
);

    localparam int c_gap_w = (EJECT_GAP < 2) ? 1 : $clog2(EJECT_GAP);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [c_coin_w-1:0] r_coins_left;
    logic [c_coin_w-1:0] w_coins_nxt;
    logic [c_gap_w-1:0]  r_gap_cnt;
    logic [c_gap_w-1:0]  w_gap_nxt;
    logic                r_overflow;

    logic [c_coin_w-1:0] w_fifo_data;
    logic                w_fifo_full;
    logic                w_fifo_empty;
    logic                w_pop;
    logic                w_push;

    // The head is consumed only in LOAD, which is entered only with data queued.
    assign w_pop  = (r_state == S_LOAD);
    assign w_push = i_soda && (!w_fifo_full || w_pop);

    change_fifo u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (i_change),
        .o_data  (w_fifo_data),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

`ifdef DISPENSE_TIMEOUT_EN
    localparam int c_ack_w = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT);
    logic [c_ack_w-1:0] r_ack_cnt;
    logic [c_ack_w-1:0] w_ack_nxt;
`else
    logic w_unused_cfg;
    assign w_unused_cfg = (ACK_TIMEOUT == 0);
`endif

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state      <= S_IDLE;
            r_coins_left <= '0;
            r_gap_cnt    <= '0;
            r_overflow   <= 1'b0;
`ifdef DISPENSE_TIMEOUT_EN
            r_ack_cnt    <= '0;
`endif
        end else begin
            r_state      <= w_state_nxt;
            r_coins_left <= w_coins_nxt;
            r_gap_cnt    <= w_gap_nxt;
`ifdef DISPENSE_TIMEOUT_EN
            r_ack_cnt    <= w_ack_nxt;
`endif
            if (i_soda && w_fifo_full && !w_pop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_coins_nxt = r_coins_left;
        w_gap_nxt   = r_gap_cnt;
`ifdef DISPENSE_TIMEOUT_EN
        w_ack_nxt   = r_ack_cnt;
`endif
        case (r_state)
            S_IDLE: begin
                if (!w_fifo_empty) begin
                    w_state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                w_coins_nxt = w_fifo_data;
                w_state_nxt = (w_fifo_data == '0) ? S_DONE : S_EJECT;
`ifdef DISPENSE_TIMEOUT_EN
                w_ack_nxt   = '0;
`endif
            end
            S_EJECT: begin
                if (i_eject_ack) begin
                    // Saturate at zero so the count can never wrap.
                    if (r_coins_left != '0) begin
                        w_coins_nxt = r_coins_left - c_nickel;
                    end
                    w_gap_nxt = '0;
`ifdef DISPENSE_TIMEOUT_EN
                    w_ack_nxt = '0;
`endif
                    if (r_coins_left <= c_nickel) begin
                        w_state_nxt = S_DONE;
                    end else if (EJECT_GAP == 0) begin
                        w_state_nxt = S_EJECT;
                    end else begin
                        w_state_nxt = S_GAP;
                    end
                end
`ifdef DISPENSE_TIMEOUT_EN
                else if (r_ack_cnt == c_ack_w'(ACK_TIMEOUT - 1)) begin
                    w_state_nxt = S_FAULT;
                end else begin
                    w_ack_nxt = r_ack_cnt + c_ack_w'(1);
                end
`endif
            end
            S_GAP: begin
                if (r_gap_cnt == c_gap_w'(EJECT_GAP - 1)) begin
                    w_state_nxt = S_EJECT;
`ifdef DISPENSE_TIMEOUT_EN
                    w_ack_nxt   = '0;
`endif
                end else begin
                    w_gap_nxt = r_gap_cnt + c_gap_w'(1);
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
`ifdef DISPENSE_TIMEOUT_EN
            S_FAULT: begin
                w_state_nxt = S_FAULT;
            end
`endif
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign o_eject      = (r_state == S_EJECT);
    assign o_coins_left = r_coins_left;
    assign o_busy       = (r_state != S_IDLE) || !w_fifo_empty;
    assign o_done       = (r_state == S_DONE);
    assign o_overflow   = r_overflow;
`ifdef DISPENSE_TIMEOUT_EN
    assign o_fault      = (r_state == S_FAULT);
`else
    assign o_fault      = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_coin_dispenser.sv
`default_nettype none
// ============================================================================
// Module      : tb_coin_dispenser
// Description : Directed self-checking bench for coin_dispenser
//               (EJECT_GAP=4, ACK_TIMEOUT=10). The timeout scenario runs
//               only when DISPENSE_TIMEOUT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_coin_dispenser;

    logic       r_clk = 1'b0;
    logic       r_rst_n = 1'b0;
    logic       r_soda = 1'b0;
    logic [2:0] r_change = 3'd0;
    logic       r_ack = 1'b0;
    logic       w_eject;
    logic [2:0] w_coins_left;
    logic       w_busy;
    logic       w_done;
    logic       w_overflow;
    logic       w_fault;

    int n_checks = 0;
    int n_fail   = 0;
    int n_done   = 0;
    int n_eject  = 0;
    logic r_eject_d = 1'b0;

    coin_dispenser #(
        .EJECT_GAP   (4),
        .ACK_TIMEOUT (10)
    ) dut (
        .i_clk        (r_clk),
        .i_rst_n      (r_rst_n),
        .i_soda       (r_soda),
        .i_change     (r_change),
        .o_eject      (w_eject),
        .i_eject_ack  (r_ack),
        .o_coins_left (w_coins_left),
        .o_busy       (w_busy),
        .o_done       (w_done),
        .o_overflow   (w_overflow),
        .o_fault      (w_fault)
    );

    always #5 r_clk = ~r_clk;

    // Event counters sampled on the falling edge, away from the active edge.
    always @(negedge r_clk) begin
        if (w_done) n_done++;
        if (w_eject && !r_eject_d) n_eject++;
        r_eject_d = w_eject;
    end

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge r_clk);
        #1;
    endtask

    task automatic strobe(input int change);
        r_soda   = 1'b1;
        r_change = 3'(change);
        tick();
        r_soda   = 1'b0;
        r_change = 3'd0;
    endtask

    // Waits (bounded) until o_eject is high.
    task automatic wait_eject();
        int n;
        n = 0;
        while (!w_eject && n < 20) begin
            tick();
            n++;
        end
        check("wait_eject", int'(w_eject), 1);
    endtask

    // Starting in the first EJECT cycle with k nickels owed: ack one cycle
    // after each eject rises, check the 4-cycle gaps and the done pulse.
    task automatic serve(input int k);
        for (int c = k; c > 0; c--) begin
            check("eject_on", int'(w_eject), 1);
            check("coins_owed", int'(w_coins_left), c);
            tick();
            check("eject_hold", int'(w_eject), 1);
            r_ack = 1'b1;
            tick();
            r_ack = 1'b0;
            check("coins_dec", int'(w_coins_left), c - 1);
            if (c > 1) begin
                check("gap1_eject", int'(w_eject), 0);
                r_ack = 1'b1;           // stray ack inside GAP must be ignored
                tick();
                r_ack = 1'b0;
                check("gap_ack_ignored", int'(w_coins_left), c - 1);
                check("gap2_eject", int'(w_eject), 0);
                tick();
                check("gap3_eject", int'(w_eject), 0);
                tick();
                check("gap4_eject", int'(w_eject), 0);
                tick();
            end else begin
                check("done_pulse", int'(w_done), 1);
                check("done_eject", int'(w_eject), 0);
                tick();
                check("done_once", int'(w_done), 0);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, e0;
        logic seen;

        // Reset state
        r_rst_n = 1'b0;
        tick();
        tick();
        check("rst_eject", int'(w_eject), 0);
        check("rst_coins", int'(w_coins_left), 0);
        check("rst_busy", int'(w_busy), 0);
        check("rst_done", int'(w_done), 0);
        check("rst_overflow", int'(w_overflow), 0);
        check("rst_fault", int'(w_fault), 0);
        r_rst_n = 1'b1;
        tick();

        // Stray ack while idle changes nothing
        r_ack = 1'b1;
        tick();
        r_ack = 1'b0;
        check("idle_ack_coins", int'(w_coins_left), 0);
        check("idle_ack_busy", int'(w_busy), 0);

        // Zero change: no eject, done 3 cycles after the strobe
        d0 = n_done;
        e0 = n_eject;
        strobe(0);
        check("z_busy", int'(w_busy), 1);
        check("z_done1", int'(w_done), 0);
        tick();
        check("z_done2", int'(w_done), 0);
        tick();
        check("z_done3", int'(w_done), 1);
        check("z_eject", int'(w_eject), 0);
        tick();
        check("z_done_off", int'(w_done), 0);
        check("z_idle", int'(w_busy), 0);
        check("z_no_eject", n_eject - e0, 0);
        check("z_done_cnt", n_done - d0, 1);

        // Change of 3: eject 3 cycles after strobe, 3 ejects, one done
        d0 = n_done;
        e0 = n_eject;
        strobe(3);
        check("c3_lat1", int'(w_eject), 0);
        tick();
        check("c3_lat2", int'(w_eject), 0);
        tick();
        check("c3_lat3", int'(w_eject), 1);
        serve(3);
        check("c3_idle", int'(w_busy), 0);
        check("c3_eject_cnt", n_eject - e0, 3);
        check("c3_done_cnt", n_done - d0, 1);

        // Overflow: a vend of 1 stalls in EJECT, 2 and 1 queue, 4 is dropped
        strobe(1);
        wait_eject();
        strobe(2);
        strobe(1);
        check("ov_before", int'(w_overflow), 0);
        strobe(4);
        check("ov_set", int'(w_overflow), 1);
        tick();
        tick();
        check("ov_stall_eject", int'(w_eject), 1);
        check("ov_stall_coins", int'(w_coins_left), 1);
        e0 = n_eject;
        serve(1);
        wait_eject();
        serve(2);
        wait_eject();
        serve(1);
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (w_eject) seen = 1'b1;
        end
        check("ov_dropped_no_eject", int'(seen), 0);
        check("ov_eject_cnt", n_eject - e0, 3);
        check("ov_idle", int'(w_busy), 0);
        check("ov_sticky", int'(w_overflow), 1);

        // Reset mid-dispense with 2 owed
        strobe(3);
        wait_eject();
        r_ack = 1'b1;
        tick();
        r_ack = 1'b0;
        check("mr_coins2", int'(w_coins_left), 2);
        r_rst_n = 1'b0;
        tick();
        check("mr_eject", int'(w_eject), 0);
        check("mr_coins", int'(w_coins_left), 0);
        check("mr_busy", int'(w_busy), 0);
        check("mr_done", int'(w_done), 0);
        check("mr_overflow", int'(w_overflow), 0);
        check("mr_fault", int'(w_fault), 0);
        r_rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (w_eject || w_busy) seen = 1'b1;
        end
        check("mr_abandoned", int'(seen), 0);

`ifdef DISPENSE_TIMEOUT_EN
        // No ack: FAULT after 10 EJECT cycles, held until reset
        strobe(1);
        wait_eject();
        for (int i = 1; i < 10; i++) begin
            tick();
            check("to_waiting", int'(w_eject), 1);
        end
        check("to_no_fault_yet", int'(w_fault), 0);
        tick();
        check("to_fault", int'(w_fault), 1);
        check("to_eject_off", int'(w_eject), 0);
        r_ack = 1'b1;
        tick();
        tick();
        r_ack = 1'b0;
        check("to_fault_held", int'(w_fault), 1);
        check("to_eject_held", int'(w_eject), 0);
        r_rst_n = 1'b0;
        tick();
        r_rst_n = 1'b1;
        check("to_fault_cleared", int'(w_fault), 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
